// File: rtl/pair_judge_if.sv
// Selection / game-status bundle between the cursor and selection blocks
// (master side) and pair_judge (slave side).
//   start, confirm   : button levels; pair_judge edge-detects them
//   secim1, secim2   : first- and second-pick cursor squares
//   colors           : 2-bit colour per square, square i at [2i+1:2i]
//   step             : game step (0001 IDLE .. 0101 DONE)
//   matched, show    : found-pair mask, face-up mask
//   score, tries     : pairs found, completed attempts (saturating)
//   hit, miss        : one-cycle result pulses
interface pair_judge_if;
  logic        start;
  logic        confirm;
  logic [2:0]  secim1;
  logic [2:0]  secim2;
  logic [15:0] colors;
  logic [3:0]  step;
  logic [7:0]  matched;
  logic [7:0]  show;
  logic [2:0]  score;
  logic [7:0]  tries;
  logic        hit;
  logic        miss;

  modport master (
    output start, confirm, secim1, secim2, colors,
    input  step, matched, show, score, tries, hit, miss
  );

  modport slave (
    input  start, confirm, secim1, secim2, colors,
    output step, matched, show, score, tries, hit, miss
  );
endinterface

// File: rtl/pair_judge.sv
// Match evaluation and game sequencing for the 8-square colour game.
// Latches two picks on confirm presses, reveals them for REVEAL_CYCLES,
// then either retires the pair into the matched mask or hides it again.
//   clk25MHz : system clock, rising edge
//   reset    : synchronous, active-high
//   bus      : pair_judge_if.slave (buttons, picks, colours in; status out)
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | waiting for a start press
// S_PICK1  | waiting for the first pick on an unmatched square
// S_PICK2  | first pick shown, waiting for a different unmatched square
// S_REVEAL | both picks shown, counting out the reveal window
// S_DONE   | all four pairs found, waiting for start to replay
module pair_judge #(
  parameter int unsigned REVEAL_CYCLES = 25_000_000
) (
  input logic         clk25MHz,
  input logic         reset,
  pair_judge_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'b0001,
    S_PICK1  = 4'b0010,
    S_PICK2  = 4'b0011,
    S_REVEAL = 4'b0100,
    S_DONE   = 4'b0101
  } state_t;

  localparam logic [24:0] CNT_LAST = 25'(REVEAL_CYCLES - 1);

  function automatic logic [7:0] onehot(input logic [2:0] idx);
    return 8'b1 << idx;
  endfunction

  function automatic logic [1:0] color_of(input logic [15:0] c, input logic [2:0] idx);
    return c[{idx, 1'b0} +: 2];
  endfunction

  state_t      state_q, state_d;
  logic        start_dly_q, confirm_dly_q;
  logic [2:0]  sel_a_q, sel_a_d;
  logic [2:0]  sel_b_q, sel_b_d;
  logic [24:0] cnt_q, cnt_d;
  logic [7:0]  matched_q, matched_d;
  logic [2:0]  score_q, score_d;
  logic [7:0]  tries_q, tries_d;
  logic        hit_q, hit_d;
  logic        miss_q, miss_d;

  logic start_edge, confirm_edge;

  // Delay registers are cleared by reset, so a button held through reset
  // looks like a fresh press on the first cycle afterwards.
  assign start_edge   = bus.start & ~start_dly_q;
  assign confirm_edge = bus.confirm & ~confirm_dly_q;

  always_ff @(posedge clk25MHz) begin
    if (reset) begin
      state_q       <= S_IDLE;
      start_dly_q   <= 1'b0;
      confirm_dly_q <= 1'b0;
      sel_a_q       <= '0;
      sel_b_q       <= '0;
      cnt_q         <= '0;
      matched_q     <= '0;
      score_q       <= '0;
      tries_q       <= '0;
      hit_q         <= 1'b0;
      miss_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_dly_q   <= bus.start;
      confirm_dly_q <= bus.confirm;
      sel_a_q       <= sel_a_d;
      sel_b_q       <= sel_b_d;
      cnt_q         <= cnt_d;
      matched_q     <= matched_d;
      score_q       <= score_d;
      tries_q       <= tries_d;
      hit_q         <= hit_d;
      miss_q        <= miss_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_a_d   = sel_a_q;
    sel_b_d   = sel_b_q;
    cnt_d     = cnt_q;
    matched_d = matched_q;
    score_d   = score_q;
    tries_d   = tries_q;
    hit_d     = 1'b0;
    miss_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_edge) state_d = S_PICK1;
      end
      S_PICK1: begin
        if (confirm_edge && !matched_q[bus.secim1]) begin
          sel_a_d = bus.secim1;
          state_d = S_PICK2;
        end
      end
      S_PICK2: begin
        if (confirm_edge && (bus.secim2 != sel_a_q) && !matched_q[bus.secim2]) begin
          sel_b_d = bus.secim2;
          tries_d = (tries_q == 8'hFF) ? tries_q : tries_q + 8'd1;
          cnt_d   = '0;
          state_d = S_REVEAL;
        end
      end
      S_REVEAL: begin
        cnt_d = cnt_q + 25'd1;
        if (cnt_q == CNT_LAST) begin
          if (color_of(bus.colors, sel_a_q) == color_of(bus.colors, sel_b_q)) begin
            matched_d = matched_q | onehot(sel_a_q) | onehot(sel_b_q);
            score_d   = score_q + 3'd1;
            hit_d     = 1'b1;
            // score_q == 3 means this pair is the fourth and last one
            state_d   = (score_q == 3'd3) ? S_DONE : S_PICK1;
          end else begin
            miss_d  = 1'b1;
            state_d = S_PICK1;
          end
        end
      end
      S_DONE: begin
        if (start_edge) begin
          matched_d = '0;
          score_d   = '0;
          tries_d   = '0;
          state_d   = S_PICK1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.show = matched_q;
    if (state_q == S_PICK2)  bus.show = matched_q | onehot(sel_a_q);
    if (state_q == S_REVEAL) bus.show = matched_q | onehot(sel_a_q) | onehot(sel_b_q);
  end

  assign bus.step    = state_q;
  assign bus.matched = matched_q;
  assign bus.score   = score_q;
  assign bus.tries   = tries_q;
  assign bus.hit     = hit_q;
  assign bus.miss    = miss_q;

endmodule

// File: tb/tb_pair_judge.sv
// Directed bench for pair_judge: REVEAL_CYCLES=4, colors=16'hE4E4 so the
// pairs are (0,4) (1,5) (2,6) (3,7). A cycle-by-cycle vector table covers
// the main game flow, followed by held-button and tries-saturation runs.
module tb_pair_judge;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pair_judge_if bus ();

  pair_judge #(.REVEAL_CYCLES(4)) dut (
    .clk25MHz (clk),
    .reset    (rst),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, st, cf;
    logic [2:0] s1, s2;
    logic [3:0] step;
    logic [7:0] mat, show;
    logic [2:0] score;
    logic [7:0] tries;
    logic       hit, miss;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t v(logic r, logic s, logic c, logic [2:0] a, logic [2:0] b,
                             logic [3:0] stp, logic [7:0] m, logic [7:0] sh,
                             logic [2:0] sc, logic [7:0] t, logic h, logic ms);
    vec_t x;
    x.rst = r; x.st = s; x.cf = c; x.s1 = a; x.s2 = b;
    x.step = stp; x.mat = m; x.show = sh; x.score = sc; x.tries = t;
    x.hit = h; x.miss = ms;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are read there too.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Counts the REVEAL cycles including the one already showing step=4.
  task automatic wait_reveal(output int n);
    n = 1;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (bus.step == 4'h4) n++;
      else break;
    end
  endtask

  int n;
  logic [7:0] exp_tries;

  initial begin
    bus.start = 0; bus.confirm = 0; bus.secim1 = 0; bus.secim2 = 0;
    bus.colors = 16'hE4E4;

    //                rst st cf s1 s2  step mat    show   sc tries h m
    vecs.push_back(v(1, 0, 0, 0, 0, 4'h1, 8'h00, 8'h00, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 4'h1, 8'h00, 8'h00, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0, 0, 4'h2, 8'h00, 8'h00, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 4'h2, 8'h00, 8'h00, 0, 0, 0, 0));
    // first pair (0,4): hit
    vecs.push_back(v(0, 0, 1, 0, 0, 4'h3, 8'h00, 8'h01, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 4'h3, 8'h00, 8'h01, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 1, 0, 4, 4'h4, 8'h00, 8'h11, 0, 1, 0, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(v(0, 0, 0, 0, 0, 4'h4, 8'h00, 8'h11, 0, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 4'h2, 8'h11, 8'h11, 1, 1, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 4'h2, 8'h11, 8'h11, 1, 1, 0, 0));
    // (1,2): miss
    vecs.push_back(v(0, 0, 1, 1, 0, 4'h3, 8'h11, 8'h13, 1, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 4'h3, 8'h11, 8'h13, 1, 1, 0, 0));
    vecs.push_back(v(0, 0, 1, 0, 2, 4'h4, 8'h11, 8'h17, 1, 2, 0, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(v(0, 0, 0, 0, 0, 4'h4, 8'h11, 8'h17, 1, 2, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 4'h2, 8'h11, 8'h11, 1, 2, 0, 1));
    vecs.push_back(v(0, 0, 0, 0, 0, 4'h2, 8'h11, 8'h11, 1, 2, 0, 0));
    // ignored: matched square in PICK1
    vecs.push_back(v(0, 0, 1, 4, 0, 4'h2, 8'h11, 8'h11, 1, 2, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 4'h2, 8'h11, 8'h11, 1, 2, 0, 0));
    vecs.push_back(v(0, 0, 1, 1, 0, 4'h3, 8'h11, 8'h13, 1, 2, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 4'h3, 8'h11, 8'h13, 1, 2, 0, 0));
    // ignored in PICK2: same square, matched square, start edge
    vecs.push_back(v(0, 0, 1, 0, 1, 4'h3, 8'h11, 8'h13, 1, 2, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 4'h3, 8'h11, 8'h13, 1, 2, 0, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 4'h3, 8'h11, 8'h13, 1, 2, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 4'h3, 8'h11, 8'h13, 1, 2, 0, 0));
    vecs.push_back(v(0, 1, 0, 0, 0, 4'h3, 8'h11, 8'h13, 1, 2, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 4'h3, 8'h11, 8'h13, 1, 2, 0, 0));
    // (1,5): hit
    vecs.push_back(v(0, 0, 1, 0, 5, 4'h4, 8'h11, 8'h33, 1, 3, 0, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(v(0, 0, 0, 0, 0, 4'h4, 8'h11, 8'h33, 1, 3, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 4'h2, 8'h33, 8'h33, 2, 3, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 4'h2, 8'h33, 8'h33, 2, 3, 0, 0));
    // (2,6) with start+confirm together in PICK1: confirm taken
    vecs.push_back(v(0, 1, 1, 2, 0, 4'h3, 8'h33, 8'h37, 2, 3, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 4'h3, 8'h33, 8'h37, 2, 3, 0, 0));
    vecs.push_back(v(0, 0, 1, 0, 6, 4'h4, 8'h33, 8'h77, 2, 4, 0, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(v(0, 0, 0, 0, 0, 4'h4, 8'h33, 8'h77, 2, 4, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 4'h2, 8'h77, 8'h77, 3, 4, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 4'h2, 8'h77, 8'h77, 3, 4, 0, 0));
    // (3,7): last pair -> DONE
    vecs.push_back(v(0, 0, 1, 3, 0, 4'h3, 8'h77, 8'h7F, 3, 4, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 4'h3, 8'h77, 8'h7F, 3, 4, 0, 0));
    vecs.push_back(v(0, 0, 1, 0, 7, 4'h4, 8'h77, 8'hFF, 3, 5, 0, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(v(0, 0, 0, 0, 0, 4'h4, 8'h77, 8'hFF, 3, 5, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 4'h5, 8'hFF, 8'hFF, 4, 5, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 4'h5, 8'hFF, 8'hFF, 4, 5, 0, 0));
    // confirm in DONE ignored; start+confirm in DONE: start wins
    vecs.push_back(v(0, 0, 1, 0, 0, 4'h5, 8'hFF, 8'hFF, 4, 5, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 4'h5, 8'hFF, 8'hFF, 4, 5, 0, 0));
    vecs.push_back(v(0, 1, 1, 0, 0, 4'h2, 8'h00, 8'h00, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 4'h2, 8'h00, 8'h00, 0, 0, 0, 0));
    // reset on REVEAL cycle 2: pair discarded
    vecs.push_back(v(0, 0, 1, 0, 0, 4'h3, 8'h00, 8'h01, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 4'h3, 8'h00, 8'h01, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 1, 0, 4, 4'h4, 8'h00, 8'h11, 0, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 4'h4, 8'h00, 8'h11, 0, 1, 0, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 4'h1, 8'h00, 8'h00, 0, 0, 0, 0));
    for (int i = 0; i < 2; i++)
      vecs.push_back(v(0, 0, 0, 0, 0, 4'h1, 8'h00, 8'h00, 0, 0, 0, 0));
    // confirm in IDLE ignored
    vecs.push_back(v(0, 0, 1, 0, 0, 4'h1, 8'h00, 8'h00, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 4'h1, 8'h00, 8'h00, 0, 0, 0, 0));
    // start held through reset gives an edge right after reset
    vecs.push_back(v(1, 1, 0, 0, 0, 4'h1, 8'h00, 8'h00, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0, 0, 4'h2, 8'h00, 8'h00, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0, 0, 4'h2, 8'h00, 8'h00, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 4'h2, 8'h00, 8'h00, 0, 0, 0, 0));

    #1;
    foreach (vecs[i]) begin
      rst = vecs[i].rst; bus.start = vecs[i].st; bus.confirm = vecs[i].cf;
      bus.secim1 = vecs[i].s1; bus.secim2 = vecs[i].s2;
      cyc();
      chk($sformatf("row%0d step", i),    32'(bus.step),    32'(vecs[i].step));
      chk($sformatf("row%0d matched", i), 32'(bus.matched), 32'(vecs[i].mat));
      chk($sformatf("row%0d show", i),    32'(bus.show),    32'(vecs[i].show));
      chk($sformatf("row%0d score", i),   32'(bus.score),   32'(vecs[i].score));
      chk($sformatf("row%0d tries", i),   32'(bus.tries),   32'(vecs[i].tries));
      chk($sformatf("row%0d hit", i),     32'(bus.hit),     32'(vecs[i].hit));
      chk($sformatf("row%0d miss", i),    32'(bus.miss),    32'(vecs[i].miss));
    end

    // Confirm held for 10 cycles in PICK1 counts once; secim2 is a legal
    // second pick so a spurious re-edge would be visible as step 0100.
    bus.confirm = 1; bus.secim1 = 0; bus.secim2 = 4;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk($sformatf("held%0d step", i), 32'(bus.step), 32'h3);
    end
    chk("held tries", 32'(bus.tries), 32'd0);
    bus.confirm = 0; cyc();
    bus.confirm = 1; cyc();
    chk("held second step", 32'(bus.step), 32'h4);
    bus.confirm = 0;
    wait_reveal(n);
    chk("reveal length", 32'(n), 32'd4);
    chk("held hit", 32'(bus.hit), 32'd1);
    chk("held matched", 32'(bus.matched), 32'h11);
    chk("held score", 32'(bus.score), 32'd1);
    chk("held tries after", 32'(bus.tries), 32'd1);

    // Repeated misses on (1,2): tries saturates at 255.
    exp_tries = 8'd1;
    for (int i = 0; i < 260; i++) begin
      bus.secim1 = 1; bus.confirm = 1; cyc();
      bus.confirm = 0; cyc();
      bus.secim2 = 2; bus.confirm = 1; cyc();
      bus.confirm = 0;
      if (exp_tries != 8'hFF) exp_tries = exp_tries + 8'd1;
      wait_reveal(n);
      chk($sformatf("miss%0d pulse", i), 32'(bus.miss), 32'd1);
      chk($sformatf("miss%0d tries", i), 32'(bus.tries), 32'(exp_tries));
    end
    chk("tries saturated", 32'(bus.tries), 32'd255);
    chk("score after misses", 32'(bus.score), 32'd1);
    chk("step after misses", 32'(bus.step), 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
